// File: rtl/nios2_ocimem_arb_pkg.sv
// Shared types and jdo field positions for the OCI RAM access arbiter.
// Also holds the strobe-to-operation decode used by the JTAG request slot.
package nios2_ocimem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AV_RD = 2'd1,
    JT_RD = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    JT_NONE  = 2'd0,
    JT_LOAD  = 2'd1,
    JT_READ  = 2'd2,
    JT_WRITE = 2'd3
  } jt_op_e;

  localparam int JDO_W         = 38;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RD_BIT    = 35;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

  // action_a takes precedence if both strobes arrive in the same cycle
  function automatic jt_op_e decode_jdo(input logic act_a, input logic act_b, input logic rd_flag);
    if (act_a)
      return rd_flag ? JT_READ : JT_LOAD;
    else if (act_b)
      return JT_WRITE;
    else
      return JT_NONE;
  endfunction

endpackage

// File: rtl/nios2_ocimem_jtag_req_slot.sv
// One-entry holding slot for JTAG OCI RAM requests, with the auto-incrementing
// JTAG word address and the sticky overrun flag.
module nios2_ocimem_jtag_req_slot
  import nios2_ocimem_arb_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [JDO_W-1:0]  i_jdo,
  input  logic              i_take_a,
  input  logic              i_take_b,
  input  logic              i_grant,
  output logic              o_valid,
  output jt_op_e            o_op,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_wdata,
  output logic              o_accept,
  output logic              o_load_done,
  output logic              o_overrun
);

  jt_op_e              w_op;
  logic                w_strobe;
  logic                w_room;
  logic                w_take;
  logic                w_unused_jdo;

  logic                r_valid;
  jt_op_e              r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_overrun;

  assign w_op     = decode_jdo(i_take_a, i_take_b, i_jdo[JDO_RD_BIT]);
  assign w_strobe = (w_op != JT_NONE);
  // A slot being granted this cycle frees up in time for a new strobe
  assign w_room   = !r_valid || i_grant;
  assign w_take   = w_strobe && w_room;

  assign o_accept     = w_take && (w_op != JT_LOAD);
  assign o_load_done  = w_take && (w_op == JT_LOAD);
  assign w_unused_jdo = ^{i_jdo[JDO_W-1:JDO_RD_BIT+1], i_jdo[JDO_WDATA_LSB-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_op      <= JT_NONE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_strobe && !w_room)
        r_overrun <= 1'b1;

      if (o_accept) begin
        r_valid <= 1'b1;
        r_op    <= w_op;
      end else if (i_grant) begin
        r_valid <= 1'b0;
        r_op    <= JT_NONE;
      end

      // A fresh address load overrides the post-write increment
      if (w_take && (w_op != JT_WRITE))
        r_addr <= i_jdo[JDO_ADDR_LSB +: ADDR_W];
      else if (i_grant && (r_op == JT_WRITE))
        r_addr <= r_addr + 1'b1;

      if (w_take && (w_op == JT_WRITE))
        r_wdata <= i_jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
    end
  end

  assign o_valid   = r_valid;
  assign o_op      = r_op;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/nios2_ocimem_access_arbiter.sv
// Arbitrates the single-port OCI RAM between the JTAG debug slot and the
// Avalon debug port, with a bounded JTAG burst before Avalon is forced in.
module nios2_ocimem_access_arbiter
  import nios2_ocimem_arb_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int MAX_JTAG_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  localparam int CNT_W = $clog2(MAX_JTAG_BURST + 1);

  arb_state_e          r_state;
  logic [CNT_W-1:0]    r_burst_cnt;
  logic [31:0]         r_mon_dreg;
  logic                r_mon_ready;

  logic                w_slot_valid;
  jt_op_e              w_slot_op;
  logic [ADDR_W-1:0]   w_jaddr;
  logic [31:0]         w_jwdata;
  logic                w_slot_accept;
  logic                w_load_done;

  logic                w_av_req;
  logic                w_idle;
  logic                w_force_av;
  logic                w_jt_grant;
  logic                w_av_grant;
  logic                w_jt_wr;
  logic                w_jt_rd;
  logic                w_av_wr;
  logic                w_av_rd;
  logic                w_av_rd_done;

  nios2_ocimem_jtag_req_slot #(
    .ADDR_W (ADDR_W)
  ) u_slot (
    .clk         (clk),
    .rst         (reset),
    .i_jdo       (jdo),
    .i_take_a    (take_action_ocimem_a),
    .i_take_b    (take_action_ocimem_b),
    .i_grant     (w_jt_grant),
    .o_valid     (w_slot_valid),
    .o_op        (w_slot_op),
    .o_addr      (w_jaddr),
    .o_wdata     (w_jwdata),
    .o_accept    (w_slot_accept),
    .o_load_done (w_load_done),
    .o_overrun   (jtag_overrun)
  );

  // Grants are suppressed while reset is held so no RAM strobe escapes
  assign w_av_req     = av_read | av_write;
  assign w_idle       = (r_state == IDLE) && !reset;
  assign w_force_av   = w_av_req && (r_burst_cnt == CNT_W'(MAX_JTAG_BURST));
  assign w_jt_grant   = w_idle && w_slot_valid && !w_force_av;
  assign w_av_grant   = w_idle && w_av_req && !w_jt_grant;
  assign w_jt_wr      = w_jt_grant && (w_slot_op == JT_WRITE);
  assign w_jt_rd      = w_jt_grant && (w_slot_op == JT_READ);
  assign w_av_wr      = w_av_grant && av_write;
  assign w_av_rd      = w_av_grant && !av_write;
  assign w_av_rd_done = (r_state == AV_RD) && !reset;

  always_comb begin
    ram_addr  = av_address;
    ram_wdata = av_writedata;
    ram_be    = av_byteenable;
    if (w_jt_grant) begin
      ram_addr  = w_jaddr;
      ram_wdata = w_jwdata;
      ram_be    = 4'hF;
    end
  end

  assign ram_we         = w_jt_wr | w_av_wr;
  assign ram_re         = w_jt_rd | w_av_rd;
  assign av_waitrequest = w_av_req && !(w_av_wr || w_av_rd_done);
  assign av_readdata    = w_av_rd_done ? ram_rdata : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
      r_mon_dreg  <= '0;
      r_mon_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_jt_rd)
            r_state <= JT_RD;
          else if (w_av_rd)
            r_state <= AV_RD;
        end
        AV_RD: r_state <= IDLE;
        JT_RD: begin
          r_state    <= IDLE;
          r_mon_dreg <= ram_rdata;
        end
        default: r_state <= IDLE;
      endcase

      if (!w_av_req || w_av_grant)
        r_burst_cnt <= '0;
      else if (w_jt_grant && (r_burst_cnt != CNT_W'(MAX_JTAG_BURST)))
        r_burst_cnt <= r_burst_cnt + 1'b1;

      // A newly queued op means the previous result is no longer "the" answer
      if (w_slot_accept)
        r_mon_ready <= 1'b0;
      else if (w_load_done || w_jt_wr || (r_state == JT_RD))
        r_mon_ready <= 1'b1;
    end
  end

  assign MonDReg       = r_mon_dreg;
  assign monitor_ready = r_mon_ready;

endmodule
